// File: rtl/multicycle_control_ws_if.sv
// Decode fields, memory handshake and datapath control bundle
// for the multi-cycle controller.
interface multicycle_control_ws_if #(
  parameter int OPW  = 3,
  parameter int FNW  = 4,
  parameter int CNTW = 16
);
  logic [OPW+FNW-1:0] input_control;
  logic               MemReady;
  logic               Stall;
  logic               Resume;
  logic               Branch;
  logic               IoD;
  logic               IRWrite;
  logic               Mem2Reg;
  logic               MemR;
  logic               MemW;
  logic               PCSrc;
  logic               PCWrite;
  logic               RegWrite;
  logic [1:0]         ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         BranchType;
  logic [3:0]         ALUOp;
  logic [3:0]         State;
  logic               Trap;
  logic [1:0]         TrapCause;
  logic               Halted;
  logic               InstrDone;
  logic [CNTW-1:0]    InstrCount;

  modport master (
    input  input_control, MemReady, Stall, Resume,
    output Branch, IoD, IRWrite, Mem2Reg, MemR, MemW,
    output PCSrc, PCWrite, RegWrite,
    output ALUSrcA, ALUSrcB, BranchType, ALUOp, State,
    output Trap, TrapCause, Halted, InstrDone, InstrCount
  );

  modport slave (
    output input_control, MemReady, Stall, Resume,
    input  Branch, IoD, IRWrite, Mem2Reg, MemR, MemW,
    input  PCSrc, PCWrite, RegWrite,
    input  ALUSrcA, ALUSrcB, BranchType, ALUOp, State,
    input  Trap, TrapCause, Halted, InstrDone, InstrCount
  );
endinterface

// File: rtl/multicycle_control_ws.sv
// Multi-cycle control FSM with memory wait states, stall,
// trap/halt handling and a saturating retire counter.
module multicycle_control_ws #(
  parameter int OPW         = 3,
  parameter int FNW         = 4,
  parameter int HALT_OP     = 7,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNTW        = 16
) (
  input logic                     CLK,
  input logic                     Reset,
  multicycle_control_ws_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_RTYPE  = 4'd2,
    S_RITYPE = 4'd3,
    S_RTEND  = 4'd4,
    S_LW1    = 4'd5,
    S_LW2    = 4'd6,
    S_SW     = 4'd7,
    S_JALR   = 4'd8,
    S_BR     = 4'd9,
    S_BR2    = 4'd10,
    S_JAL    = 4'd11,
    S_TRAP   = 4'd12,
    S_HALT   = 4'd13
  } state_e;

  localparam int WW = (MEM_TIMEOUT > 1) ?
                      $clog2(MEM_TIMEOUT) : 1;
  localparam bit TO_EN = (MEM_TIMEOUT > 0);
  localparam logic [WW-1:0] WLAST =
    TO_EN ? WW'(MEM_TIMEOUT - 1) : '0;

  state_e          state_q, state_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [1:0]      cause_q, cause_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [OPW-1:0]  opc;
  logic [3:0]      fn;
  logic            mem_st;
  logic            done;

  assign opc = bus.input_control[OPW-1:0];
  assign fn  = bus.input_control[OPW+3:OPW];

  // 9/10 are lw/sw address adds; 11 and 13-15 have no ALU op
  function automatic logic [3:0] alu_fn(input logic [3:0] f);
    logic [3:0] r;
    r = 4'b1111;
    if (f <= 4'd8)                  r = f;
    else if (f == 4'd9 || f == 4'd10) r = 4'b0000;
    else if (f == 4'd12)            r = 4'b1100;
    return r;
  endfunction

  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    cause_d        = cause_q;
    cnt_d          = cnt_q;
    mem_st         = 1'b0;
    done           = 1'b0;
    bus.Branch     = 1'b0;
    bus.IoD        = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.Mem2Reg    = 1'b0;
    bus.MemR       = 1'b0;
    bus.MemW       = 1'b0;
    bus.PCSrc      = 1'b0;
    bus.PCWrite    = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.ALUSrcA    = 2'd0;
    bus.ALUSrcB    = 2'd0;
    bus.BranchType = 2'd0;
    bus.ALUOp      = 4'b1111;
    bus.Trap       = 1'b0;
    bus.Halted     = 1'b0;
    bus.InstrDone  = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_st      = 1'b1;
        bus.MemR    = 1'b1;
        bus.ALUSrcB = 2'd1;
        bus.ALUOp   = 4'b0000;
        if (bus.MemReady) begin
          bus.IRWrite = 1'b1;
          bus.PCWrite = 1'b1;
          state_d     = S_DECODE;
        end
      end
      S_DECODE: begin
        if (opc == OPW'(0)) begin
          state_d = S_RTYPE;
        end else if (opc == OPW'(1)) begin
          if (fn == 4'b1011)       state_d = S_JALR;
          else if (fn[3:2] == 2'b11) state_d = S_BR;
          else                       state_d = S_RITYPE;
        end else if (opc == OPW'(2)) begin
          state_d = S_RITYPE;
        end else if (opc == OPW'(3)) begin
          state_d = S_FETCH;
          done    = 1'b1;
        end else if (opc == OPW'(4)) begin
          state_d = S_JAL;
        end else if (opc == OPW'(HALT_OP)) begin
          state_d = S_HALT;
          done    = 1'b1;
        end else begin
          state_d = S_TRAP;
          cause_d = 2'd1;
        end
      end
      S_RTYPE: begin
        bus.ALUSrcA = 2'd2;
        bus.ALUOp   = alu_fn(fn);
        state_d     = S_RTEND;
      end
      S_RITYPE: begin
        bus.ALUSrcA = 2'd2;
        bus.ALUSrcB = 2'd2;
        bus.ALUOp   = alu_fn(fn);
        if (fn == 4'd9)       state_d = S_LW1;
        else if (fn == 4'd10) state_d = S_SW;
        else                  state_d = S_RTEND;
      end
      S_RTEND: begin
        bus.RegWrite = 1'b1;
        state_d      = S_FETCH;
        done         = 1'b1;
      end
      S_LW1: begin
        mem_st   = 1'b1;
        bus.IoD  = 1'b1;
        bus.MemR = 1'b1;
        if (bus.MemReady) state_d = S_LW2;
      end
      S_LW2: begin
        bus.RegWrite = 1'b1;
        bus.Mem2Reg  = 1'b1;
        state_d      = S_FETCH;
        done         = 1'b1;
      end
      S_SW: begin
        mem_st   = 1'b1;
        bus.IoD  = 1'b1;
        bus.MemW = 1'b1;
        if (bus.MemReady) begin
          state_d = S_FETCH;
          done    = 1'b1;
        end
      end
      S_JALR: begin
        bus.ALUOp    = 4'b0111;
        bus.ALUSrcA  = 2'd3;
        bus.ALUSrcB  = 2'd1;
        bus.RegWrite = 1'b1;
        state_d      = S_FETCH;
        done         = 1'b1;
      end
      S_BR: begin
        bus.ALUOp      = 4'b1001;
        bus.ALUSrcB    = 2'd2;
        bus.Branch     = 1'b1;
        bus.BranchType = fn[1:0];
        state_d        = S_BR2;
      end
      S_BR2: begin
        bus.ALUOp      = 4'b0001;
        bus.ALUSrcA    = 2'd2;
        bus.Branch     = 1'b1;
        bus.BranchType = fn[1:0];
        bus.PCSrc      = 1'b1;
        bus.PCWrite    = 1'b1;
        state_d        = S_FETCH;
        done           = 1'b1;
      end
      S_JAL: begin
        bus.PCWrite = 1'b1;
        bus.ALUOp   = 4'b0111;
        bus.ALUSrcA = 2'd3;
        bus.ALUSrcB = 2'd1;
        state_d     = S_FETCH;
        done        = 1'b1;
      end
      S_TRAP: begin
        bus.Trap = 1'b1;
        state_d  = S_HALT;
      end
      S_HALT: begin
        bus.Halted = 1'b1;
        if (bus.Resume) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // a late MemReady on the last allowed cycle still completes
    if (TO_EN && mem_st && !bus.MemReady) begin
      if (wait_q == WLAST) begin
        state_d = S_TRAP;
        cause_d = 2'd2;
      end else begin
        wait_d = wait_q + 1'b1;
      end
    end
    if (state_d != state_q) wait_d = '0;

    if (bus.Stall) begin
      state_d      = state_q;
      wait_d       = wait_q;
      cause_d      = cause_q;
      done         = 1'b0;
      bus.Trap     = 1'b0;
      bus.MemR     = 1'b0;
      bus.MemW     = 1'b0;
      bus.IRWrite  = 1'b0;
      bus.PCWrite  = 1'b0;
      bus.RegWrite = 1'b0;
    end
    if (!Reset) begin
      bus.MemR     = 1'b0;
      bus.MemW     = 1'b0;
      bus.IRWrite  = 1'b0;
      bus.PCWrite  = 1'b0;
      bus.RegWrite = 1'b0;
    end
    bus.InstrDone = done;
    if (done && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      cause_q <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.State      = state_q;
  assign bus.TrapCause  = cause_q;
  assign bus.InstrCount = cnt_q;

endmodule

// File: tb/tb_multicycle_control_ws.sv
// Randomised bench for multicycle_control_ws against an
// instruction-path reference model.
module tb_multicycle_control_ws;

  typedef logic [3:0] q4_t[$];

  logic CLK;
  logic Reset;
  int   checks = 0;
  int   errors = 0;
  int   cnt_m = 0;
  int   cause_m = 0;

  multicycle_control_ws_if #(.OPW(3), .FNW(4), .CNTW(16)) bus ();
  multicycle_control_ws_if #(.OPW(3), .FNW(4), .CNTW(2))  bus2 ();

  multicycle_control_ws #(
    .OPW(3), .FNW(4), .HALT_OP(7), .MEM_TIMEOUT(16), .CNTW(16)
  ) dut (
    .CLK(CLK), .Reset(Reset), .bus(bus)
  );

  multicycle_control_ws #(
    .OPW(3), .FNW(4), .HALT_OP(7), .MEM_TIMEOUT(16), .CNTW(2)
  ) dut2 (
    .CLK(CLK), .Reset(Reset), .bus(bus2)
  );

  assign bus2.input_control = bus.input_control;
  assign bus2.MemReady      = bus.MemReady;
  assign bus2.Stall         = bus.Stall;
  assign bus2.Resume        = bus.Resume;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: no finish within time limit");
    $fatal(1);
  end

  // state sequence an instruction walks through, by spec rules
  function automatic q4_t build_path(input logic [2:0] op,
                                     input logic [3:0] fn);
    q4_t p;
    p.push_back(4'd0);
    p.push_back(4'd1);
    if (op == 3'd1 && fn == 4'd11) begin
      p.push_back(4'd8);
    end else if (op == 3'd1 && fn[3:2] == 2'b11) begin
      p.push_back(4'd9);
      p.push_back(4'd10);
    end else if (op == 3'd1 || op == 3'd2) begin
      p.push_back(4'd3);
      if (fn == 4'd9) begin
        p.push_back(4'd5);
        p.push_back(4'd6);
      end else if (fn == 4'd10) begin
        p.push_back(4'd7);
      end else begin
        p.push_back(4'd4);
      end
    end else if (op == 3'd0) begin
      p.push_back(4'd2);
      p.push_back(4'd4);
    end else if (op == 3'd4) begin
      p.push_back(4'd11);
    end
    return p;
  endfunction

  function automatic logic [3:0] exp_aluop(input int st,
                                           input logic [3:0] fn);
    case (st)
      0:       return 4'd0;
      2, 3: begin
        if (fn <= 4'd8) return fn;
        if (fn == 4'd9 || fn == 4'd10) return 4'd0;
        if (fn == 4'd12) return 4'd12;
        return 4'd15;
      end
      8, 11:   return 4'd7;
      9:       return 4'd9;
      10:      return 4'd1;
      default: return 4'd15;
    endcase
  endfunction

  function automatic logic [3:0] exp_src(input int st);
    case (st)
      0:       return 4'b0001;
      2:       return 4'b1000;
      3:       return 4'b1010;
      8, 11:   return 4'b1101;
      9:       return 4'b0010;
      10:      return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic int pick(input int wfix);
    if (wfix >= 0) return wfix;
    return int'($urandom_range(0, 4));
  endfunction

  task automatic run_instr(input logic [2:0] op,
                           input logic [3:0] fn,
                           input int wfix,
                           input int stall_at,
                           input bit rnd_stall);
    q4_t        path;
    int         idx, waits, stl, guard, st, sat;
    bit         rdy, stall, adv, mem, last, once;
    logic [11:0] ctl, ectl;
    path  = build_path(op, fn);
    idx   = 0;
    guard = 0;
    stl   = 0;
    once  = 0;
    waits = pick(wfix);
    bus.input_control = {fn, op};
    while (idx < path.size() && guard < 300) begin
      guard++;
      st  = int'(path[idx]);
      mem = (st == 0 || st == 5 || st == 7);
      if (!once && st == stall_at) begin
        stl  = 3;
        once = 1;
      end
      stall = (stl > 0) || (rnd_stall && $urandom_range(0, 4) == 0);
      rdy   = mem ? (waits == 0) : 1'($urandom_range(0, 1));
      bus.Stall    = stall;
      bus.MemReady = rdy;
      adv  = !stall && (!mem || rdy);
      last = (idx == path.size() - 1);
      sat  = (cnt_m > 3) ? 3 : cnt_m;
      ectl = {!stall && (st == 0 || st == 5),
              !stall && st == 7,
              !stall && (st == 4 || st == 6 || st == 8),
              !stall && ((st == 0 && rdy) || st == 10 || st == 11),
              !stall && st == 0 && rdy,
              st == 5 || st == 7,
              st == 6,
              st == 9 || st == 10,
              st == 10,
              adv && last,
              1'b0,
              1'b0};
      @(negedge CLK);
      ctl = {bus.MemR, bus.MemW, bus.RegWrite, bus.PCWrite,
             bus.IRWrite, bus.IoD, bus.Mem2Reg, bus.Branch,
             bus.PCSrc, bus.InstrDone, bus.Trap, bus.Halted};
      checks++;
      if (bus.State !== 4'(st)) begin
        errors++;
        $display("FAIL state op=%0d fn=%0d got=%0d exp=%0d",
                 op, fn, bus.State, st);
      end
      checks++;
      if (ctl !== ectl) begin
        errors++;
        $display("FAIL ctrl st=%0d stall=%0b got=%b exp=%b",
                 st, stall, ctl, ectl);
      end
      checks++;
      if (bus.ALUOp !== exp_aluop(st, fn)) begin
        errors++;
        $display("FAIL aluop st=%0d fn=%0d got=%0d exp=%0d",
                 st, fn, bus.ALUOp, exp_aluop(st, fn));
      end
      checks++;
      if ({bus.ALUSrcA, bus.ALUSrcB} !== exp_src(st)) begin
        errors++;
        $display("FAIL alusrc st=%0d got=%b exp=%b", st,
                 {bus.ALUSrcA, bus.ALUSrcB}, exp_src(st));
      end
      if (st == 9 || st == 10) begin
        checks++;
        if (bus.BranchType !== fn[1:0]) begin
          errors++;
          $display("FAIL brtype got=%0d exp=%0d",
                   bus.BranchType, fn[1:0]);
        end
      end
      checks++;
      if (bus.InstrCount !== 16'(cnt_m) ||
          bus2.InstrCount !== 2'(sat)) begin
        errors++;
        $display("FAIL count got=%0d/%0d exp=%0d/%0d",
                 bus.InstrCount, bus2.InstrCount, cnt_m, sat);
      end
      @(posedge CLK);
      #1;
      if (stl > 0) stl--;
      if (adv) begin
        if (last) cnt_m++;
        idx++;
        waits = pick(wfix);
      end else if (!stall && mem) begin
        waits--;
      end
    end
    bus.Stall = 1'b0;
    checks++;
    if (guard >= 300) begin
      errors++;
      $display("FAIL instr_guard got=%0d exp=<300", guard);
    end
  endtask

  task automatic test_reset;
    Reset             = 1'b0;
    bus.MemReady      = 1'b1;
    bus.Stall         = 1'b0;
    bus.Resume        = 1'b0;
    bus.input_control = '0;
    repeat (2) @(posedge CLK);
    #1;
    @(negedge CLK);
    checks++;
    if (bus.State !== 4'd0 || bus.InstrCount !== 16'd0 ||
        bus2.InstrCount !== 2'd0 || bus.TrapCause !== 2'd0) begin
      errors++;
      $display("FAIL reset_state got=%0d/%0d/%0d exp=0/0/0",
               bus.State, bus.InstrCount, bus.TrapCause);
    end
    checks++;
    if ({bus.MemR, bus.IRWrite, bus.PCWrite} !== 3'b000) begin
      errors++;
      $display("FAIL reset_we got=%b exp=000",
               {bus.MemR, bus.IRWrite, bus.PCWrite});
    end
    @(posedge CLK);
    #1;
    Reset = 1'b1;
    cnt_m = 0;
    cause_m = 0;
  endtask

  task automatic test_rtype;
    run_instr(3'd0, 4'd0, 0, -1, 1'b0);
    bus.Stall = 1'b1;
    @(negedge CLK);
    checks++;
    if (bus.InstrCount !== 16'd1) begin
      errors++;
      $display("FAIL rtype_count got=%0d exp=1", bus.InstrCount);
    end
    @(posedge CLK);
    #1;
    bus.Stall = 1'b0;
  endtask

  task automatic test_lw;
    run_instr(3'd2, 4'd9, 3, -1, 1'b0);
  endtask

  task automatic test_fetch_edge;
    run_instr(3'd0, 4'd1, 15, -1, 1'b0);
  endtask

  task automatic test_timeout;
    int n;
    int c;
    n = 0;
    c = 0;
    bus.MemReady = 1'b0;
    bus.input_control = '0;
    while (c < 40) begin
      bus.Stall = (c == 5 || c == 6);
      @(negedge CLK);
      if (bus.State !== 4'd0) break;
      if (!bus.Stall) n++;
      c++;
      @(posedge CLK);
      #1;
    end
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL timeout_len got=%0d exp=16", n);
    end
    checks++;
    if (bus.State !== 4'd12 || bus.Trap !== 1'b1 ||
        bus.TrapCause !== 2'd2) begin
      errors++;
      $display("FAIL timeout_trap got=%0d/%0b/%0d exp=12/1/2",
               bus.State, bus.Trap, bus.TrapCause);
    end
    checks++;
    if ({bus.MemR, bus.MemW, bus.RegWrite, bus.PCWrite,
         bus.IRWrite, bus.InstrDone} !== 6'd0) begin
      errors++;
      $display("FAIL trap_we got=%b exp=000000",
               {bus.MemR, bus.MemW, bus.RegWrite, bus.PCWrite,
                bus.IRWrite, bus.InstrDone});
    end
    cause_m = 2;
    @(posedge CLK);
    #1;
    @(negedge CLK);
    checks++;
    if (bus.State !== 4'd13 || bus.Halted !== 1'b1 ||
        bus.Trap !== 1'b0 || bus.InstrCount !== 16'(cnt_m)) begin
      errors++;
      $display("FAIL halt got=%0d/%0b/%0b/%0d exp=13/1/0/%0d",
               bus.State, bus.Halted, bus.Trap, bus.InstrCount,
               cnt_m);
    end
    @(posedge CLK);
    #1;
    bus.Resume = 1'b1;
    @(posedge CLK);
    #1;
    bus.Resume = 1'b0;
    bus.Stall  = 1'b1;
    @(negedge CLK);
    checks++;
    if (bus.State !== 4'd0 || bus.TrapCause !== 2'd2) begin
      errors++;
      $display("FAIL resume got=%0d/%0d exp=0/2",
               bus.State, bus.TrapCause);
    end
    @(posedge CLK);
    #1;
    bus.Stall = 1'b0;
  endtask

  task automatic test_decode_exit(input logic [2:0] op);
    int  exp_st[$];
    bit  trap;
    trap = (op != 3'd7);
    if (trap) exp_st = '{0, 1, 12, 13};
    else      exp_st = '{0, 1, 13};
    bus.input_control = {4'($urandom_range(0, 15)), op};
    bus.MemReady = 1'b1;
    bus.Stall    = 1'b0;
    foreach (exp_st[i]) begin
      @(negedge CLK);
      checks++;
      if (bus.State !== 4'(exp_st[i]) ||
          bus.Trap !== (exp_st[i] == 12) ||
          bus.Halted !== (exp_st[i] == 13) ||
          bus.InstrDone !== (!trap && i == 1)) begin
        errors++;
        $display("FAIL decode_exit op=%0d i=%0d got=%0d/%0b/%0b/%0b exp=%0d",
                 op, i, bus.State, bus.Trap, bus.Halted,
                 bus.InstrDone, exp_st[i]);
      end
      @(posedge CLK);
      #1;
      if (!trap && i == 1) cnt_m++;
    end
    if (trap) cause_m = 1;
    @(negedge CLK);
    checks++;
    if (bus.State !== 4'd13 || bus.TrapCause !== 2'(cause_m) ||
        bus.InstrCount !== 16'(cnt_m)) begin
      errors++;
      $display("FAIL decode_halt op=%0d got=%0d/%0d/%0d exp=13/%0d/%0d",
               op, bus.State, bus.TrapCause, bus.InstrCount,
               cause_m, cnt_m);
    end
    @(posedge CLK);
    #1;
    bus.Resume = 1'b1;
    @(posedge CLK);
    #1;
    bus.Resume = 1'b0;
  endtask

  task automatic test_branch_stall;
    logic [3:0] fn;
    fn = {2'b11, 2'($urandom_range(0, 3))};
    if (fn == 4'd11) fn = 4'd12;
    run_instr(3'd1, fn, 0, 10, 1'b0);
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++)
      run_instr(3'($urandom_range(0, 4)),
                4'($urandom_range(0, 15)), -1, -1, 1'b1);
  endtask

  task automatic test_reset_sw;
    int exp_st[3];
    exp_st = '{0, 1, 3};
    bus.input_control = {4'd10, 3'd2};
    bus.MemReady = 1'b1;
    bus.Stall    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++;
      if (bus.State !== 4'(exp_st[i])) begin
        errors++;
        $display("FAIL sw_path got=%0d exp=%0d",
                 bus.State, exp_st[i]);
      end
      @(posedge CLK);
      #1;
    end
    bus.MemReady = 1'b0;
    @(negedge CLK);
    checks++;
    if (bus.State !== 4'd7 || bus.MemW !== 1'b1) begin
      errors++;
      $display("FAIL sw_wait got=%0d/%0b exp=7/1",
               bus.State, bus.MemW);
    end
    @(posedge CLK);
    #1;
    Reset = 1'b0;
    @(negedge CLK);
    checks++;
    if (bus.MemW !== 1'b0) begin
      errors++;
      $display("FAIL sw_reset_memw got=%0b exp=0", bus.MemW);
    end
    @(posedge CLK);
    #1;
    @(negedge CLK);
    checks++;
    if (bus.State !== 4'd0 || bus.InstrCount !== 16'd0 ||
        bus2.InstrCount !== 2'd0 || bus.TrapCause !== 2'd0) begin
      errors++;
      $display("FAIL sw_reset got=%0d/%0d/%0d exp=0/0/0",
               bus.State, bus.InstrCount, bus.TrapCause);
    end
    @(posedge CLK);
    #1;
    Reset   = 1'b1;
    cnt_m   = 0;
    cause_m = 0;
  endtask

  task automatic test_saturate;
    for (int i = 0; i < 5; i++)
      run_instr(3'($urandom_range(0, 4)),
                4'($urandom_range(0, 15)), -1, -1, 1'b0);
    bus.Stall = 1'b1;
    @(negedge CLK);
    checks++;
    if (bus2.InstrCount !== 2'd3 || bus.InstrCount !== 16'd5) begin
      errors++;
      $display("FAIL saturate got=%0d/%0d exp=3/5",
               bus2.InstrCount, bus.InstrCount);
    end
    @(posedge CLK);
    #1;
    bus.Stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw();
    test_fetch_edge();
    test_timeout();
    test_decode_exit(3'd5);
    test_decode_exit(3'd7);
    test_branch_stall();
    test_random(60);
    test_reset_sw();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_ws.md
Name: multicycle_control_ws

Overview:
- Parametrised successor to the multi-cycle control FSM of the 16-bit processor. Drives the same datapath control signals.
- Adds memory wait-state handshaking (MemReady), a pipeline-freeze Stall input, an illegal-opcode / memory-timeout trap, a HALT state with Resume, and a retired-instruction counter.
- Sits between the instruction register decode fields and the datapath muxes, register file and memory.

Parameters:
- OPW, 3, opcode field width (input_control[OPW-1:0])
- FNW, 4, funct field width (input_control[OPW+FNW-1:OPW]); must be >=4
- HALT_OP, 7, opcode value that enters HALT
- MEM_TIMEOUT, 16, max wait cycles per memory access before trap; 0 disables the timeout
- CNTW, 16, retired-instruction counter width

Ports:
- CLK  in  1  clock, all state on rising edge
- Reset  in  1  synchronous, active-low reset
- input_control  in  OPW+FNW  {funct, opcode} from IR
- MemReady  in  1  memory completes the current access this cycle
- Stall  in  1  freeze FSM and suppress all write enables
- Resume  in  1  leave HALT
- Branch, IoD, IRWrite, Mem2Reg, MemR, MemW, PCSrc, PCWrite, RegWrite  out  1 each  datapath controls
- ALUSrcA, ALUSrcB, BranchType  out  2 each  datapath controls
- ALUOp  out  4  ALU operation
- State  out  4  current state encoding
- Trap  out  1  one-cycle pulse on trap entry
- TrapCause  out  2  0 none, 1 illegal opcode, 2 memory timeout; held until Reset
- Halted  out  1  high while in HALT
- InstrDone  out  1  one-cycle retire pulse
- InstrCount  out  CNTW  retired instructions, saturating

Behaviour:
- State encoding: FETCH 0, DECODE 1, RTYPE 2, RITYPE 3, RTYPEEND 4, LW1 5, LW2 6, SW 7, JALR 8, BRANCH 9, BRANCH2 10, JAL 11, TRAP 12, HALT 13. Undefined codes go to FETCH on the next edge.
- Reset (Reset==0 at an edge): State=FETCH, wait counter 0, TrapCause=0, InstrCount=0.
  - While Reset is low, MemR, MemW, IRWrite, PCWrite and RegWrite are forced to 0.
  - Reset mid-access abandons the access.
- Outputs are combinational from State. Defaults: ALUOp=4'b1111; all other outputs 0.
- Stall=1: State and wait counter hold. MemR, MemW, IRWrite, PCWrite, RegWrite, InstrDone and Trap are 0. Stall wins over MemReady.
- FETCH: MemR=1, IoD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=0000.
  - MemReady=0: stay in FETCH.
  - MemReady=1: IRWrite=1 and PCWrite=1 that cycle, next state DECODE.
- DECODE: next state selected by opcode.
  - 0 → RTYPE.
  - 1 → JALR if funct[3:0]=1011; BRANCH if funct[3:2]=11; otherwise RITYPE.
  - 2 → RITYPE.
  - 3 → FETCH; this retires the instruction.
  - 4 → JAL.
  - HALT_OP → HALT; retires.
  - Any other opcode → TRAP with TrapCause=1.
- ALUOp in RTYPE/RITYPE: funct[3:0] 0–8 pass through unchanged; 9 and 10 → 0000 (address add); 12 → 1100; else 1111.
- RTYPE: ALUSrcA=2, ALUSrcB=0 → RTYPEEND.
- RITYPE: ALUSrcA=2, ALUSrcB=2.
  - funct 9 → LW1.
  - funct 10 → SW.
  - otherwise → RTYPEEND.
- RTYPEEND: RegWrite=1, Mem2Reg=0 → FETCH; retires.
- LW1: IoD=1, MemR=1. Waits for MemReady, then → LW2.
- LW2: RegWrite=1, Mem2Reg=1 → FETCH; retires.
- SW: IoD=1, MemW=1. Waits for MemReady, then → FETCH; retires.
- JALR: ALUOp=0111, ALUSrcA=3, ALUSrcB=1, RegWrite=1 → FETCH; retires.
- BRANCH: ALUOp=1001, ALUSrcA=0, ALUSrcB=2, Branch=1, BranchType=funct[1:0] → BRANCH2.
- BRANCH2: ALUOp=0001, ALUSrcA=2, ALUSrcB=0, Branch=1, BranchType=funct[1:0], PCSrc=1, PCWrite=1 → FETCH; retires.
- JAL: PCWrite=1, ALUOp=0111, ALUSrcA=3, ALUSrcB=1 → FETCH; retires.
- Memory timeout (FETCH, LW1, SW):
  - The wait counter clears on entry to each of these states.
  - It increments on every non-stalled cycle with MemReady=0.
  - If the counter equals MEM_TIMEOUT-1 and MemReady=0, the next state is TRAP with TrapCause=2.
  - If MemReady=1 arrives in that same cycle, MemReady wins.
- TRAP: Trap=1 for exactly one cycle, all write enables 0 → HALT.
- HALT: Halted=1, all write enables 0.
  - Resume=1 → FETCH; TrapCause is preserved.
  - Only Reset clears TrapCause.
- Retire: InstrDone=1 in the final cycle of an instruction, i.e. the cycle whose next state is FETCH or HALT on normal completion.
  - InstrCount increments on the following edge and saturates at all ones.
  - TRAP does not retire.
- Latency with MemReady always high and no stall:
  - R-type 4 cycles; lw 5; sw 4; branch 4; jal/jalr 3; L-type 2.

Test Plan:
- Reset low 2 cycles, then high; R-type add (opcode 0, funct 0), MemReady=1 → states 0,1,2,4,0; RegWrite=1 only in state 4; InstrCount=1.
- lw (opcode 2, funct 9) with MemReady low for 3 cycles in LW1 → LW1 held 4 cycles with MemR=1 and IoD=1; LW2 asserts RegWrite=1, Mem2Reg=1; one InstrDone.
- FETCH with MemReady stuck 0, MEM_TIMEOUT=16 → TRAP after 16 FETCH cycles; Trap pulses once; TrapCause=2; Halted=1; Resume → FETCH with TrapCause still 2.
- Opcode 5 → DECODE→TRAP→HALT; TrapCause=1; InstrCount unchanged.
- Stall=1 for 3 cycles during BRANCH2 → State stays 10 and PCWrite=0; after release PCWrite=1 for one cycle and BranchType=funct[1:0].
- Reset asserted during SW wait → next State=0, MemW=0 immediately, InstrCount=0; CNTW=2 with 5 retires → InstrCount=3.
